// File: rtl/cluster_unpacker.sv
// cluster_unpacker
//
// Rebuilds the 1536-strip S-bit hit map from a cluster list of up to
// MXCLUSTERS (address, count, valid) triples. A latch_in pulse captures the
// whole list into a working buffer. One cluster per clock is then expanded
// into a strip mask and ORed into an accumulator. The finished map is
// published on vpfs_out together with a one-cycle valid_out pulse, 9 cycles
// after latch_in.
//
// Ports
//   clock      : single clock, rising edge
//   reset_n    : asynchronous active-low reset
//   latch_in   : one-cycle pulse, cluster inputs valid this cycle
//   vpf_in     : per-cluster valid flags
//   adr_in     : cluster addresses, cluster i at [11i+10:11i]
//   cnt_in     : cluster counts, cluster i at [3i+2:3i] (covers cnt+1 strips)
//   vpfs_out   : reconstructed strip map, held between frames
//   valid_out  : one-cycle pulse, vpfs_out updated this cycle
//   busy       : a frame is being expanded
//   overflow   : one-cycle pulse, frame aborted by an early latch_in
//   err_adr    : one-cycle pulse, a valid cluster had an out-of-range address
//   err_cnt    : saturating count of err_adr pulses
//
// Build option
//   CLUSTER_UNPACK_ERR_EN : when defined, the address range checker drives
//   err_adr/err_cnt. When undefined, both outputs are tied to 0. Out-of-range
//   clusters are skipped in either build.

module cluster_unpacker #(
    parameter int MXCLUSTERS = 8,
    parameter int MXSTRIPS   = 1536,
    parameter int MXADRBITS  = 11,
    parameter int MXCNTBITS  = 3
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            latch_in,
    input  logic [MXCLUSTERS-1:0]           vpf_in,
    input  logic [MXCLUSTERS*MXADRBITS-1:0] adr_in,
    input  logic [MXCLUSTERS*MXCNTBITS-1:0] cnt_in,
    output logic [MXSTRIPS-1:0]             vpfs_out,
    output logic                            valid_out,
    output logic                            busy,
    output logic                            overflow,
    output logic                            err_adr,
    output logic [15:0]                     err_cnt
);

    localparam logic [MXADRBITS-1:0] ADR_LIMIT = MXADRBITS'(MXSTRIPS);
    localparam logic [2:0]           LAST_IDX  = 3'(MXCLUSTERS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state;
    logic [2:0]             idx;

    // Stage 0: captured cluster list
    logic                   vpf_p0 [MXCLUSTERS];
    logic [MXADRBITS-1:0]   adr_p0 [MXCLUSTERS];
    logic [MXCNTBITS-1:0]   cnt_p0 [MXCLUSTERS];

    // Stage 1: strip accumulator for the frame in flight
    logic [MXSTRIPS-1:0]    acc_p1;

    logic                   cur_vpf;
    logic [MXADRBITS-1:0]   cur_adr;
    logic [MXCNTBITS-1:0]   cur_cnt;
    logic [MXSTRIPS-1:0]    mask;
    logic                   last;
    logic                   proc;

    // Strip mask covering [adr, adr+cnt]. The run of ones is shifted inside a
    // MXSTRIPS-wide vector, so anything past the top strip falls off the end
    // rather than wrapping to strip 0.
    function automatic logic [MXSTRIPS-1:0] cluster_mask(
        input logic                 vpf,
        input logic [MXADRBITS-1:0] adr,
        input logic [MXCNTBITS-1:0] cnt
    );
        logic [7:0]          run;
        logic [MXSTRIPS-1:0] m;
        run = 8'hFF >> (3'd7 - cnt);
        m   = '0;
        if (vpf && (adr < ADR_LIMIT)) begin
            m = MXSTRIPS'(run) << adr;
        end
        return m;
    endfunction

    always_comb begin
        cur_vpf = vpf_p0[idx];
        cur_adr = adr_p0[idx];
        cur_cnt = cnt_p0[idx];
        mask    = cluster_mask(cur_vpf, cur_adr, cur_cnt);
        last    = (state == RUN) && (idx == LAST_IDX);
        // A cluster counts as processed unless a relatch discards it; the last
        // cluster always completes, even with a new latch_in in that cycle.
        proc    = (state == RUN) && (!latch_in || (idx == LAST_IDX));
    end

    assign busy = (state == RUN);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            acc_p1    <= '0;
            vpfs_out  <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
            for (int i = 0; i < MXCLUSTERS; i++) begin
                vpf_p0[i] <= 1'b0;
                adr_p0[i] <= '0;
                cnt_p0[i] <= '0;
            end
        end else begin
            valid_out <= 1'b0;
            overflow  <= 1'b0;

            // Stage 2: publish the completed frame
            if (last) begin
                vpfs_out  <= acc_p1 | mask;
                valid_out <= 1'b1;
            end

            if (latch_in) begin
                for (int i = 0; i < MXCLUSTERS; i++) begin
                    vpf_p0[i] <= vpf_in[i];
                    adr_p0[i] <= adr_in[i*MXADRBITS +: MXADRBITS];
                    cnt_p0[i] <= cnt_in[i*MXCNTBITS +: MXCNTBITS];
                end
                acc_p1 <= '0;
                idx    <= '0;
                state  <= RUN;
                if ((state == RUN) && (idx != LAST_IDX)) begin
                    overflow <= 1'b1;
                end
            end else if (state == RUN) begin
                acc_p1 <= acc_p1 | mask;
                idx    <= idx + 3'd1;
                if (idx == LAST_IDX) begin
                    state <= IDLE;
                end
            end
        end
    end

`ifdef CLUSTER_UNPACK_ERR_EN
    logic bad_adr;

    assign bad_adr = proc && cur_vpf && (cur_adr >= ADR_LIMIT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_adr <= 1'b0;
            err_cnt <= '0;
        end else begin
            err_adr <= bad_adr;
            if (bad_adr && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`else
    logic unused_proc;

    assign unused_proc = proc;
    assign err_adr     = 1'b0;
    assign err_cnt     = '0;
`endif

endmodule

// File: tb/tb_cluster_unpacker.sv
module tb_cluster_unpacker;

    localparam int MXCLUSTERS = 8;
    localparam int MXSTRIPS   = 1536;
    localparam int MXADRBITS  = 11;
    localparam int MXCNTBITS  = 3;
`ifdef CLUSTER_UNPACK_ERR_EN
    localparam int ERR = 1;
`else
    localparam int ERR = 0;
`endif
    localparam int NVEC = 6;

    logic                            clock;
    logic                            reset_n;
    logic                            latch_in;
    logic [MXCLUSTERS-1:0]           vpf_in;
    logic [MXCLUSTERS*MXADRBITS-1:0] adr_in;
    logic [MXCLUSTERS*MXCNTBITS-1:0] cnt_in;
    logic [MXSTRIPS-1:0]             vpfs_out;
    logic                            valid_out;
    logic                            busy;
    logic                            overflow;
    logic                            err_adr;
    logic [15:0]                     err_cnt;

    cluster_unpacker dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .latch_in  (latch_in),
        .vpf_in    (vpf_in),
        .adr_in    (adr_in),
        .cnt_in    (cnt_in),
        .vpfs_out  (vpfs_out),
        .valid_out (valid_out),
        .busy      (busy),
        .overflow  (overflow),
        .err_adr   (err_adr),
        .err_cnt   (err_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // One frame of stimulus plus hand-computed expectations: the expected map
    // is given as up to 8 inclusive strip ranges (lo > hi marks an unused one),
    // and errk is the cycle after latch_in where err_adr should pulse (0: none).
    typedef struct {
        logic [7:0]        vpf;
        logic [7:0][10:0]  adr;
        logic [7:0][2:0]   cnt;
        logic [7:0][11:0]  lo;
        logic [7:0][11:0]  hi;
        int                errk;
    } vec_t;

    vec_t tbl [NVEC];
    int   n_vec;
    int   n_bad;
    int   exp_ec;

    task automatic vclr(input int i);
        tbl[i].vpf  = '0;
        tbl[i].adr  = '0;
        tbl[i].cnt  = '0;
        tbl[i].lo   = '1;
        tbl[i].hi   = '0;
        tbl[i].errk = 0;
    endtask

    task automatic add_cl(input int i, input int slot, input logic vp, input int adr, input int cnt);
        tbl[i].vpf[slot] = vp;
        tbl[i].adr[slot] = 11'(adr);
        tbl[i].cnt[slot] = 3'(cnt);
    endtask

    task automatic add_rg(input int i, input int r, input int lo, input int hi);
        tbl[i].lo[r] = 12'(lo);
        tbl[i].hi[r] = 12'(hi);
    endtask

    function automatic logic [MXSTRIPS-1:0] build_map(input int i);
        logic [MXSTRIPS-1:0] m;
        m = '0;
        for (int r = 0; r < 8; r++) begin
            for (int s = int'(tbl[i].lo[r]); s <= int'(tbl[i].hi[r]); s++) begin
                m[s] = 1'b1;
            end
        end
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_map(input string name, input logic [MXSTRIPS-1:0] exp);
        int first;
        n_vec++;
        if (vpfs_out !== exp) begin
            n_bad++;
            first = -1;
            for (int s = MXSTRIPS - 1; s >= 0; s--) begin
                if (vpfs_out[s] !== exp[s]) first = s;
            end
            $display("FAIL %s: map differs, first strip %0d got %b expected %b, popcount got %0d expected %0d",
                     name, first, vpfs_out[first], exp[first], $countones(vpfs_out), $countones(exp));
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int i);
        vpf_in = tbl[i].vpf;
        adr_in = tbl[i].adr;
        cnt_in = tbl[i].cnt;
    endtask

    // Garbage on the inputs once a frame is captured; the map must come from
    // the working buffer.
    task automatic scramble();
        vpf_in = 8'hFF;
        adr_in = {$urandom, $urandom, $urandom};
        cnt_in = 24'($urandom);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " valid_out"}, 32'(valid_out), 0);
        chk({tag, " busy"},      32'(busy),      0);
        chk({tag, " overflow"},  32'(overflow),  0);
        chk({tag, " err_adr"},   32'(err_adr),   0);
        chk({tag, " err_cnt"},   32'(err_cnt),   0);
        chk_map({tag, " vpfs_out"}, '0);
    endtask

    initial begin
        n_vec    = 0;
        n_bad    = 0;
        exp_ec   = 0;
        reset_n  = 1'b0;
        latch_in = 1'b0;
        vpf_in   = '0;
        adr_in   = '0;
        cnt_in   = '0;

        // v0: single cluster 100..103
        vclr(0); add_cl(0, 0, 1, 100, 3); add_rg(0, 0, 100, 103);
        // v1: clipping at the top strip
        vclr(1); add_cl(1, 0, 1, 1533, 7); add_cl(1, 1, 1, 1535, 0); add_rg(1, 0, 1533, 1535);
        // v2: full frame, 8 clusters of 8 strips every 200
        vclr(2);
        for (int k = 0; k < 8; k++) begin
            add_cl(2, k, 1, 200 * k, 7);
            add_rg(2, k, 200 * k, 200 * k + 7);
        end
        // v3: overlap, duplicate, vpf gap, out-of-range in slot 6
        vclr(3);
        add_cl(3, 0, 1, 0, 7);    add_cl(3, 1, 1, 4, 7);
        add_cl(3, 2, 1, 500, 1);  add_cl(3, 3, 1, 500, 1);
        add_cl(3, 5, 0, 900, 7);  add_cl(3, 6, 1, 1600, 3);
        add_cl(3, 7, 1, 1000, 2);
        add_rg(3, 0, 0, 11); add_rg(3, 1, 500, 501); add_rg(3, 2, 1000, 1002);
        tbl[3].errk = 8;
        // v4: out-of-range address in slot 2
        vclr(4); add_cl(4, 0, 1, 10, 0); add_cl(4, 2, 1, 1600, 0); add_rg(4, 0, 10, 10);
        tbl[4].errk = 4;
        // v5: same address but not valid
        vclr(5); add_cl(5, 0, 1, 10, 0); add_cl(5, 2, 0, 1600, 0); add_cl(5, 4, 0, 2047, 7);
        add_rg(5, 0, 10, 10);

        step();
        step();
        chk_all_zero("reset");
        reset_n = 1'b1;
        step();

        // Isolated frames
        for (int i = 0; i < NVEC; i++) begin
            drive(i);
            latch_in = 1'b1;
            for (int k = 1; k <= 10; k++) begin
                step();
                if (k == 1) begin
                    latch_in = 1'b0;
                    scramble();
                end
                chk($sformatf("v%0d k%0d valid_out", i, k), 32'(valid_out), 32'(k == 9));
                chk($sformatf("v%0d k%0d busy", i, k),      32'(busy),      32'(k <= 8));
                chk($sformatf("v%0d k%0d overflow", i, k),  32'(overflow),  0);
                chk($sformatf("v%0d k%0d err_adr", i, k),   32'(err_adr),
                    32'((ERR != 0) && (k == tbl[i].errk)));
                if (k == 9) chk_map($sformatf("v%0d map", i), build_map(i));
            end
            if (tbl[i].errk != 0) exp_ec += ERR;
            chk($sformatf("v%0d err_cnt", i), 32'(err_cnt), 32'(exp_ec));
            step();
        end

        // Back-to-back frames 8 cycles apart
        drive(2);
        latch_in = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            step();
            if (k == 1 || k == 9) begin
                latch_in = 1'b0;
                scramble();
            end
            chk($sformatf("b2b k%0d valid_out", k), 32'(valid_out), 32'(k == 9 || k == 17));
            chk($sformatf("b2b k%0d overflow", k),  32'(overflow),  0);
            chk($sformatf("b2b k%0d busy", k),      32'(busy),      32'(k <= 16));
            chk($sformatf("b2b k%0d err_adr", k),   32'(err_adr),   32'((ERR != 0) && (k == 16)));
            if (k == 9)  chk_map("b2b first map", build_map(2));
            if (k == 17) chk_map("b2b second map", build_map(3));
            if (k == 8) begin
                drive(3);
                latch_in = 1'b1;
            end
        end
        exp_ec += ERR;
        chk("b2b err_cnt", 32'(err_cnt), 32'(exp_ec));
        step();

        // Early relatch aborts the first frame
        drive(0);
        latch_in = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k == 1 || k == 5) begin
                latch_in = 1'b0;
                scramble();
            end
            chk($sformatf("relatch k%0d overflow", k),  32'(overflow),  32'(k == 5));
            chk($sformatf("relatch k%0d valid_out", k), 32'(valid_out), 32'(k == 13));
            if (k == 13) chk_map("relatch map", build_map(1));
            if (k == 4) begin
                drive(1);
                latch_in = 1'b1;
            end
        end
        step();

        // Asynchronous reset in the middle of a frame
        drive(0);
        latch_in = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) latch_in = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        step();
        step();
        reset_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("postreset k%0d valid_out", k), 32'(valid_out), 0);
            chk($sformatf("postreset k%0d busy", k),      32'(busy),      0);
        end
        chk_map("postreset map", '0);

        // Fresh frame after reset still works
        drive(0);
        latch_in = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 1) latch_in = 1'b0;
        end
        chk("final valid_out", 32'(valid_out), 1);
        chk_map("final map", build_map(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
